rxd_frame: RTL and testbench

//  UART receive framer; consumes sample_clk from the rxd_clk rate generator (SMP_PER_BIT pulses/bit).

---
 rtl/uart_pkg.sv | 20 ++
 rtl/rxd_sync.sv | 28 ++
 rtl/rxd_frame.sv | 137 +++++++++++++
 tb/tb_rxd_frame.sv | 246 ++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART types and constants used by the receive framer and the rate generator.
package uart_pkg;

    typedef enum logic [1:0] {
        NONE = 2'd0,
        ODD  = 2'd1,
        EVEN = 2'd2
    } parity_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } rx_state_t;

    localparam int DEFAULT_SMP_PER_BIT = 9;

endpackage

// File: rtl/rxd_sync.sv
// Two-flop synchroniser for the asynchronous serial line plus a falling-edge detector.
module rxd_sync (
    input  logic clk,
    input  logic rst,
    input  logic rxd,
    output logic rxd_s,
    output logic fall
);

    logic rxd_meta;
    logic rxd_prev;

    // Flops reset to 1 so the idle-high line never looks like a start edge after reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rxd_meta <= 1'b1;
            rxd_s    <= 1'b1;
            rxd_prev <= 1'b1;
        end else begin
            rxd_meta <= rxd;
            rxd_s    <= rxd_meta;
            rxd_prev <= rxd_s;
        end
    end

    assign fall = rxd_prev & ~rxd_s;

endmodule

// File: rtl/rxd_frame.sv
// UART receive framer: start detection, per-bit majority vote, LSB-first deserialisation,
// optional parity check and early stop-bit decision.
module rxd_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS   = 8,
    parameter int PARITY_MODE = 0,
    parameter int SMP_PER_BIT = DEFAULT_SMP_PER_BIT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rxd,
    input  logic                 sample_clk,
    output logic                 rx_start,
    output logic                 rx_done,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 busy
);

    localparam int CW = $clog2(SMP_PER_BIT + 1);
    localparam int BW = $clog2(DATA_BITS + 1);
    localparam parity_t PMODE = parity_t'(PARITY_MODE[1:0]);

    localparam logic [CW-1:0] SMP_LAST  = CW'(SMP_PER_BIT - 1);
    localparam logic [CW-1:0] BIT_HALF  = CW'(SMP_PER_BIT / 2);
    localparam logic [CW-1:0] STOP_LAST = CW'((SMP_PER_BIT + 1) / 2 - 1);
    localparam logic [CW-1:0] STOP_HALF = CW'(((SMP_PER_BIT + 1) / 2) / 2);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_BITS - 1);

    rx_state_t            state;
    logic [CW-1:0]        smp_cnt;
    logic [CW-1:0]        ones_cnt;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_acc;
    logic                 par_err_q;

    logic          rxd_s;
    logic          fall;
    logic [CW-1:0] ones_total;
    logic          bit_vote;
    logic          stop_vote;
    logic          par_bad;

    rxd_sync u_sync (
        .clk   (clk),
        .rst   (rst),
        .rxd   (rxd),
        .rxd_s (rxd_s),
        .fall  (fall)
    );

    // Votes include the sample being taken this cycle.
    assign ones_total = ones_cnt + CW'(rxd_s);
    assign bit_vote   = ones_total > BIT_HALF;
    assign stop_vote  = ones_total > STOP_HALF;
    assign par_bad    = (PMODE == ODD) ? ~(par_acc ^ bit_vote) : (par_acc ^ bit_vote);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            smp_cnt    <= '0;
            ones_cnt   <= '0;
            bit_cnt    <= '0;
            shift_reg  <= '0;
            par_acc    <= 1'b0;
            par_err_q  <= 1'b0;
            rx_start   <= 1'b0;
            rx_done    <= 1'b0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            frame_err  <= 1'b0;
            parity_err <= 1'b0;
            busy       <= 1'b0;
        end else begin
            rx_start <= 1'b0;
            rx_done  <= 1'b0;
            rx_valid <= 1'b0;

            if (state == IDLE) begin
                busy     <= 1'b0;
                smp_cnt  <= '0;
                ones_cnt <= '0;
                bit_cnt  <= '0;
                if (fall) begin
                    rx_start  <= 1'b1;
                    busy      <= 1'b1;
                    par_acc   <= 1'b0;
                    par_err_q <= 1'b0;
                    state     <= START;
                end
            end else if (sample_clk) begin
                // The stop bit is judged at mid-bit so the next start edge is never missed.
                if (state == STOP && smp_cnt == STOP_LAST) begin
                    smp_cnt    <= '0;
                    ones_cnt   <= '0;
                    rx_data    <= shift_reg;
                    frame_err  <= ~stop_vote;
                    parity_err <= par_err_q;
                    rx_valid   <= 1'b1;
                    rx_done    <= 1'b1;
                    state      <= IDLE;
                end else if (smp_cnt == SMP_LAST) begin
                    smp_cnt  <= '0;
                    ones_cnt <= '0;
                    if (state == START) begin
                        if (bit_vote) begin
                            rx_done <= 1'b1;
                            state   <= IDLE;
                        end else begin
                            state <= DATA;
                        end
                    end else if (state == DATA) begin
                        shift_reg <= {bit_vote, shift_reg[DATA_BITS-1:1]};
                        par_acc   <= par_acc ^ bit_vote;
                        if (bit_cnt == BIT_LAST) begin
                            bit_cnt <= '0;
                            state   <= (PMODE == NONE) ? STOP : PARITY;
                        end else begin
                            bit_cnt <= bit_cnt + BW'(1);
                        end
                    end else if (state == PARITY) begin
                        par_err_q <= par_bad;
                        state     <= STOP;
                    end
                end else begin
                    smp_cnt  <= smp_cnt + CW'(1);
                    ones_cnt <= ones_total;
                end
            end
        end
    end

endmodule

// File: tb/tb_rxd_frame.sv
// Scoreboard bench for rxd_frame: channel 0 is 8N1, channel 1 is 8E1, each with its own sample strobe.
module tb_rxd_frame;

    localparam int DIV      = 4;
    localparam int SMP      = 9;
    localparam int BIT_CLKS = DIV * SMP;

    typedef struct {
        int         ch;
        logic [7:0] data;
        logic       ferr;
        logic       perr;
    } exp_t;

    logic            clk = 1'b0;
    logic            rst;
    logic [1:0]      rxd;
    logic [1:0]      sclk;
    logic [1:0]      gen_on;
    logic [1:0][3:0] div_cnt;
    logic [1:0]      rx_start;
    logic [1:0]      rx_done;
    logic [1:0]      rx_valid;
    logic [1:0]      frame_err;
    logic [1:0]      parity_err;
    logic [1:0]      busy;
    logic [1:0][7:0] rx_data;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   start_cnt [2];
    int   done_cnt  [2];
    int   valid_cnt [2];

    always #10 clk = ~clk;

    rxd_frame #(.DATA_BITS(8), .PARITY_MODE(0), .SMP_PER_BIT(SMP)) dut0 (
        .clk(clk), .rst(rst), .rxd(rxd[0]), .sample_clk(sclk[0]),
        .rx_start(rx_start[0]), .rx_done(rx_done[0]), .rx_data(rx_data[0]),
        .rx_valid(rx_valid[0]), .frame_err(frame_err[0]), .parity_err(parity_err[0]),
        .busy(busy[0])
    );

    rxd_frame #(.DATA_BITS(8), .PARITY_MODE(2), .SMP_PER_BIT(SMP)) dut1 (
        .clk(clk), .rst(rst), .rxd(rxd[1]), .sample_clk(sclk[1]),
        .rx_start(rx_start[1]), .rx_done(rx_done[1]), .rx_data(rx_data[1]),
        .rx_valid(rx_valid[1]), .frame_err(frame_err[1]), .parity_err(parity_err[1]),
        .busy(busy[1])
    );

    // Stand-in for the rate generator: enabled by rx_start, disabled by rx_done.
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            gen_on  <= '0;
            sclk    <= '0;
            div_cnt <= '0;
        end else begin
            for (int c = 0; c < 2; c++) begin
                sclk[c] <= 1'b0;
                if (rx_done[c]) begin
                    gen_on[c] <= 1'b0;
                end else if (rx_start[c]) begin
                    gen_on[c]  <= 1'b1;
                    div_cnt[c] <= 4'(DIV - 1);
                end else if (gen_on[c]) begin
                    if (div_cnt[c] == 4'(DIV - 1)) begin
                        div_cnt[c] <= '0;
                        sclk[c]    <= 1'b1;
                    end else begin
                        div_cnt[c] <= div_cnt[c] + 4'd1;
                    end
                end
            end
        end
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        tests++;
        if (actual !== expected) begin
            fails++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    // Reference: the word is delivered as sent; flags follow directly from the framing rules.
    function automatic exp_t model(input int ch, input logic [7:0] d, input logic p, input logic s);
        exp_t e;
        e.ch   = ch;
        e.data = d;
        e.ferr = ~s;
        e.perr = (ch == 1) ? ((^d) ^ p) : 1'b0;
        return e;
    endfunction

    // Monitor: pops one expectation per rx_valid pulse and tracks handshake pulses.
    always @(negedge clk) begin
        exp_t e;
        if (!rst) begin
            for (int c = 0; c < 2; c++) begin
                if (rx_start[c]) start_cnt[c]++;
                if (rx_done[c]) done_cnt[c]++;
                if (rx_start[c] || rx_done[c])
                    checkOutput("start_done_overlap", 32'(rx_start[c] & rx_done[c]), 32'd0);
                if (rx_valid[c]) begin
                    valid_cnt[c]++;
                    if (exp_q.size() == 0) begin
                        checkOutput("unexpected_valid", 32'd1, 32'd0);
                    end else begin
                        e = exp_q.pop_front();
                        checkOutput("valid_channel", 32'(c), 32'(e.ch));
                        checkOutput("rx_data", 32'(rx_data[c]), 32'(e.data));
                        checkOutput("frame_err", 32'(frame_err[c]), 32'(e.ferr));
                        checkOutput("parity_err", 32'(parity_err[c]), 32'(e.perr));
                        checkOutput("done_with_valid", 32'(rx_done[c]), 32'd1);
                        checkOutput("busy_at_done", 32'(busy[c]), 32'd1);
                    end
                end
            end
        end
    end

    task automatic driveBit(input int ch, input logic v);
        rxd[ch] = v;
        repeat (BIT_CLKS) @(negedge clk);
    endtask

    task automatic applyStimulus(input int ch, input logic [7:0] d, input logic p, input logic s,
                                 input int idle_bits, input bit push);
        if (push) exp_q.push_back(model(ch, d, p, s));
        driveBit(ch, 1'b0);
        for (int i = 0; i < 8; i++) driveBit(ch, d[i]);
        if (ch == 1) driveBit(ch, p);
        driveBit(ch, s);
        rxd[ch] = 1'b1;
        repeat (idle_bits) driveBit(ch, 1'b1);
    endtask

    task automatic waitDrain();
        int n = 0;
        while (exp_q.size() != 0 && n < 20 * BIT_CLKS) begin
            @(negedge clk);
            n++;
        end
        checkOutput("drain_queue", 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #1600000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int         s0, d0, v0, ch, idle;
        logic [7:0] d;
        logic       p, s;

        rst = 1'b0;
        rxd = '1;
        #3 rst = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("reset_flags", 32'({rx_start, rx_done, rx_valid, frame_err, parity_err, busy}), 32'd0);
        checkOutput("reset_data", 32'(rx_data), 32'd0);
        rst = 1'b0;
        repeat (5) @(negedge clk);

        $display("[TB] 8N1 frame 0xA5");
        s0 = start_cnt[0]; d0 = done_cnt[0]; v0 = valid_cnt[0];
        applyStimulus(0, 8'hA5, 1'b0, 1'b1, 2, 1'b1);
        waitDrain();
        checkOutput("a5_starts", 32'(start_cnt[0] - s0), 32'd1);
        checkOutput("a5_dones", 32'(done_cnt[0] - d0), 32'd1);
        checkOutput("a5_valids", 32'(valid_cnt[0] - v0), 32'd1);
        checkOutput("a5_busy_idle", 32'(busy[0]), 32'd0);

        $display("[TB] false start glitch");
        s0 = start_cnt[0]; d0 = done_cnt[0]; v0 = valid_cnt[0];
        rxd[0] = 1'b0;
        repeat (2 * DIV) @(negedge clk);
        rxd[0] = 1'b1;
        repeat (2 * BIT_CLKS) @(negedge clk);
        checkOutput("glitch_starts", 32'(start_cnt[0] - s0), 32'd1);
        checkOutput("glitch_dones", 32'(done_cnt[0] - d0), 32'd1);
        checkOutput("glitch_valids", 32'(valid_cnt[0] - v0), 32'd0);
        checkOutput("glitch_busy", 32'(busy[0]), 32'd0);

        $display("[TB] framing error then recovery");
        applyStimulus(0, 8'h3C, 1'b0, 1'b0, 2, 1'b1);
        waitDrain();
        checkOutput("frame_err_held", 32'(frame_err[0]), 32'd1);
        applyStimulus(0, 8'h01, 1'b0, 1'b1, 2, 1'b1);
        waitDrain();
        checkOutput("frame_err_cleared", 32'(frame_err[0]), 32'd0);

        $display("[TB] even parity frames");
        applyStimulus(1, 8'h07, 1'b0, 1'b1, 2, 1'b1);
        waitDrain();
        checkOutput("parity_err_held", 32'(parity_err[1]), 32'd1);
        applyStimulus(1, 8'h07, 1'b1, 1'b1, 2, 1'b1);
        waitDrain();

        $display("[TB] back-to-back frames");
        v0 = valid_cnt[0];
        applyStimulus(0, 8'h55, 1'b0, 1'b1, 0, 1'b1);
        applyStimulus(0, 8'hAA, 1'b0, 1'b1, 2, 1'b1);
        waitDrain();
        checkOutput("b2b_valids", 32'(valid_cnt[0] - v0), 32'd2);

        $display("[TB] reset mid-frame");
        fork
            applyStimulus(0, 8'hF0, 1'b0, 1'b1, 1, 1'b0);
            begin
                repeat (4 * BIT_CLKS) @(negedge clk);
                checkOutput("busy_mid_frame", 32'(busy[0]), 32'd1);
                rst = 1'b1;
                #1;
                checkOutput("midrst_flags", 32'({rx_start, rx_done, rx_valid, frame_err, parity_err, busy}), 32'd0);
                checkOutput("midrst_data", 32'(rx_data), 32'd0);
            end
        join
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        repeat (5) @(negedge clk);
        applyStimulus(0, 8'h12, 1'b0, 1'b1, 2, 1'b1);
        waitDrain();

        $display("[TB] randomized frames");
        for (int n = 0; n < 40; n++) begin
            ch   = int'($urandom_range(0, 1));
            d    = 8'($urandom);
            p    = 1'($urandom_range(0, 1));
            s    = ($urandom_range(0, 7) != 0);
            idle = s ? int'($urandom_range(0, 2)) : int'($urandom_range(1, 2));
            applyStimulus(ch, d, p, s, idle, 1'b1);
        end
        repeat (2 * BIT_CLKS) @(negedge clk);
        waitDrain();
        checkOutput("final_busy", 32'(busy), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
